pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. Generates the IF/ID hold (`Hazard`) and flush (`IF_IDFlash`) controls, the PC write enable, the ID/EX bubble and the EX hold. Decisions come from three sources: load-use dependences, taken branches/jumps resolved in EX, and multi-cycle EX operations such as multiply/divide. The block sits beside the decode stage and drives every pipeline register's hold/flush pins.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/load_use_detect.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Statistics counters are built only when PIPE_STAT_EN is defined.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam int REG_ZERO = 0;
    localparam int STAT_W   = 16;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side register specifiers and pipeline-register hold/flush controls.
// stall_cycles/flush_events exist only when PIPE_STAT_EN is defined.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5
) ();
    import pipe_ctrl_pkg::*;

    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rt;
    logic              ex_mc_start;
    logic              br_taken;

    logic              pc_write;
    logic              if_id_hazard;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              ex_hold;
`ifdef PIPE_STAT_EN
    logic [STAT_W-1:0] stall_cycles;
    logic [STAT_W-1:0] flush_events;
`endif

    // master: the pipeline datapath; slave: the hazard controller.
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_mc_start, br_taken,
`ifdef PIPE_STAT_EN
        input  stall_cycles, flush_events,
`endif
        input  pc_write, if_id_hazard, if_id_flush, id_ex_bubble, ex_hold
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_mc_start, br_taken,
`ifdef PIPE_STAT_EN
        output stall_cycles, flush_events,
`endif
        output pc_write, if_id_hazard, if_id_flush, id_ex_bubble, ex_hold
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use detector: EX holds a load whose destination the ID
// instruction reads. Register 0 is hardwired and never creates a dependence.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_uses_rt,
    output logic              o_lu
);
    logic w_rs_match;
    logic w_rt_match;
    logic w_dst_live;

    assign w_dst_live = (i_ex_rt != REG_AW'(REG_ZERO));
    assign w_rs_match = (i_ex_rt == i_id_rs);
    assign w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
    assign o_lu       = i_ex_mem_read && w_dst_live && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and multi-cycle EX holds. PIPE_STAT_EN adds stall/flush statistics.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave hc
);
    localparam int CNT_W = (MC_LAT < 2) ? 1 : $clog2(MC_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MC_LAT < 2) ? 0 : MC_LAT - 2);

    generate
        if (MC_LAT < 2) begin : g_bad_lat
            $error("pipe_hazard_ctrl: MC_LAT must be at least 2");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_lu;
    logic             w_pc_write;
    logic             w_if_id_hazard;
    logic             w_if_id_flush;
    logic             w_id_ex_bubble;
    logic             w_ex_hold;

    load_use_detect #(.REG_AW(REG_AW)) u_lu (
        .i_ex_mem_read (hc.ex_mem_read),
        .i_ex_rt       (hc.ex_rt),
        .i_id_rs       (hc.id_rs),
        .i_id_rt       (hc.id_rt),
        .i_id_uses_rt  (hc.id_uses_rt),
        .o_lu          (w_lu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_pc_write     = 1'b1;
        w_if_id_hazard = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_ex_hold      = 1'b0;
        if (rst) begin
            // Outputs follow reset immediately so the unreset IF/ID register is flushed.
            w_pc_write     = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (hc.br_taken) begin
                        w_if_id_flush  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end else if (hc.ex_mc_start) begin
                        w_pc_write     = 1'b0;
                        w_if_id_hazard = 1'b1;
                        w_ex_hold      = 1'b1;
                        w_cnt_next     = CNT_LOAD;
                        w_state_next   = MC_WAIT;
                    end else if (w_lu) begin
                        w_pc_write     = 1'b0;
                        w_if_id_hazard = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (r_cnt != '0) begin
                        w_pc_write     = 1'b0;
                        w_if_id_hazard = 1'b1;
                        w_ex_hold      = 1'b1;
                        w_cnt_next     = r_cnt - 1'b1;
                    end else begin
                        // Release cycle: the still-asserted ex_mc_start belongs to the finishing op.
                        w_state_next = RUN;
                        if (hc.br_taken) begin
                            w_if_id_flush  = 1'b1;
                            w_id_ex_bubble = 1'b1;
                        end else if (w_lu) begin
                            w_pc_write     = 1'b0;
                            w_if_id_hazard = 1'b1;
                            w_id_ex_bubble = 1'b1;
                        end
                    end
                end
                default: w_state_next = RUN;
            endcase
        end
    end

    assign hc.pc_write     = w_pc_write;
    assign hc.if_id_hazard = w_if_id_hazard;
    assign hc.if_id_flush  = w_if_id_flush;
    assign hc.id_ex_bubble = w_id_ex_bubble;
    assign hc.ex_hold      = w_ex_hold;

`ifdef PIPE_STAT_EN
    logic [STAT_W-1:0] r_stall_cycles;
    logic [STAT_W-1:0] r_flush_events;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!w_pc_write) r_stall_cycles <= sat_inc(r_stall_cycles);
            if (w_if_id_flush) r_flush_events <= sat_inc(r_flush_events);
        end
    end

    assign hc.stall_cycles = r_stall_cycles;
    assign hc.flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stimulus pushes expected control vectors
// {pc_write, if_id_hazard, if_id_flush, id_ex_bubble, ex_hold}; a monitor pops and compares.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    typedef struct {
        logic [4:0]        ctl;
        logic [STAT_W-1:0] stall;
        logic [STAT_W-1:0] flush;
        string             name;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   checks;
    int   failures;
    logic [STAT_W-1:0] exp_stall;
    logic [STAT_W-1:0] exp_flush;

    pipe_hazard_ctrl_if #(.REG_AW(5)) hc ();

    pipe_hazard_ctrl #(.REG_AW(5), .MC_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .hc  (hc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle; sample mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e   = sb_q.pop_front();
            act = {hc.pc_write, hc.if_id_hazard, hc.if_id_flush, hc.id_ex_bubble, hc.ex_hold};
            checks++;
            if (act !== e.ctl) begin
                failures++;
                $display("FAIL %s: ctl got=%b expected=%b", e.name, act, e.ctl);
            end else begin
                $display("ok   %s: ctl=%b", e.name, act);
            end
`ifdef PIPE_STAT_EN
            checks++;
            if (hc.stall_cycles !== e.stall || hc.flush_events !== e.flush) begin
                failures++;
                $display("FAIL %s_stats: stall got=%0d expected=%0d flush got=%0d expected=%0d",
                         e.name, hc.stall_cycles, e.stall, hc.flush_events, e.flush);
            end
`endif
        end
    end

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input bit ur,
                          input bit mr, input logic [4:0] ert, input bit mc, input bit br);
        hc.id_rs       = rs;
        hc.id_rt       = rt;
        hc.id_uses_rt  = ur;
        hc.ex_mem_read = mr;
        hc.ex_rt       = ert;
        hc.ex_mc_start = mc;
        hc.br_taken    = br;
    endtask

    // One cycle of stimulus, entered just after a rising edge. A pulse raises rst
    // mid-cycle and drops it (with idle inputs) before the next rising edge.
    task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit ur,
                        input bit mr, input logic [4:0] ert, input bit mc, input bit br,
                        input bit pulse, input logic [4:0] exp_ctl, input string name);
        exp_t e;
        rst = r | pulse;
        set_in(rs, rt, ur, mr, ert, mc, br);
        e.ctl   = exp_ctl;
        e.stall = (r | pulse) ? '0 : exp_stall;
        e.flush = (r | pulse) ? '0 : exp_flush;
        e.name  = name;
        sb_q.push_back(e);
        if (r | pulse) begin
            exp_stall = '0;
            exp_flush = '0;
        end else begin
            if (!exp_ctl[4] && exp_stall != '1) exp_stall = exp_stall + 1'b1;
            if (exp_ctl[2] && exp_flush != '1) exp_flush = exp_flush + 1'b1;
        end
        if (pulse) begin
            @(negedge clk);
            #1;
            rst = 1'b0;
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [4:0] E_RST  = 5'b00110;
    localparam logic [4:0] E_PASS = 5'b10000;
    localparam logic [4:0] E_LU   = 5'b01010;
    localparam logic [4:0] E_BR   = 5'b10110;
    localparam logic [4:0] E_HOLD = 5'b01001;

    initial begin
        int waited;
        checks    = 0;
        failures  = 0;
        exp_stall = '0;
        exp_flush = '0;
        rst       = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        //     rst rs     rt     ur  mr  ex_rt  mc  br  pul expected
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_RST,  "reset0");
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_RST,  "reset1");
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_RST,  "reset2");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_PASS, "idle_after_reset");
        step(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, E_LU,   "lu_rs");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_PASS, "lu_cleared");
        step(0, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 0, E_PASS, "lu_reg0");
        step(0, 5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 0, E_LU,   "lu_rt");
        step(0, 5'd3, 5'd7, 0, 1, 5'd7, 0, 0, 0, E_PASS, "lu_rt_unused");
        step(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 1, 0, E_BR,   "br_over_lu");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, E_HOLD, "mc_hold1");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, E_HOLD, "mc_hold2");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, E_HOLD, "mc_hold3");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, E_PASS, "mc_release");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_PASS, "mc_back_to_run");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, E_BR,   "br_over_mc");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, E_HOLD, "mc2_hold1");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, E_HOLD, "mc2_hold2_br_ignored");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, E_HOLD, "mc2_hold3");
        step(0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 0, E_LU,   "mc2_release_lu");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, E_HOLD, "mc3_back_to_back");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 1, E_RST,  "mc3_async_reset");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_PASS, "after_abort1");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_PASS, "after_abort2");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, E_HOLD, "mc4_hold1");
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_HOLD, "mc4_hold2");
        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
